// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state, word size and captured-request struct for the data-memory responder
package dmem_pkg;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic                    we;
    logic [31:0]             addr;
    logic [31:0]             wdata;
    logic [WORD_BYTES-1:0]   be;
  } req_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: sync-write registered-read word array (CLK, we, be, addr, wdata -> rdata); DMEM_BYTE_WRITE_EN makes be select written lanes
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
`ifdef DMEM_BYTE_WRITE_EN
  always_ff @(posedge CLK) begin
    for (int i = 0; i < WORD_BYTES; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
`else
  logic unused_be;
  assign unused_be = ^be;
  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
`endif
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated single-outstanding load/store responder (CLK, rst, req_valid/ready/we/addr/wdata/be in, resp_valid/ready/rdata/err out); DMEM_BYTE_WRITE_EN enables byte-lane stores
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          DATA_WIDTH  = 32,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [WORD_BYTES-1:0] req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t state, state_next;
  req_t live, cap, cur;
  logic [3:0] cnt;
  logic [31:0] offset;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic accept, commit, err, resp_load;
  assign live = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
  // with zero wait states the commit happens on the accept edge, so the live request feeds the array
  assign cur = (state == IDLE) ? live : cap;
  assign offset = cur.addr - BASE_ADDR;
  assign err = (offset[1:0] != 2'b00) || ((offset >> (ADDR_WIDTH + 2)) != 0);
  assign accept = req_valid && req_ready;
  assign commit = !rst && ((state == IDLE) ? (accept && WAIT_CYCLES == 0) : (state == WAIT && cnt == 4'd0));
  always_ff @(posedge CLK)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
      WAIT:    state_next = (cnt == 4'd0) ? RESP : WAIT;
      RESP:    state_next = resp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    resp_valid = (state == RESP);
  end
  always_ff @(posedge CLK) begin
    if (accept) begin
      cap <= live;
      cnt <= WAIT_LOAD;
    end else if (state == WAIT) cnt <= cnt - 4'd1;
  end
  always_ff @(posedge CLK)
    if (rst) begin
      resp_err <= 1'b0;
      resp_load <= 1'b0;
    end else if (commit) begin
      resp_err <= err;
      resp_load <= !cur.we && !err;
    end else if (state == RESP && resp_ready) begin
      resp_err <= 1'b0;
      resp_load <= 1'b0;
    end
  // the array's read register captures the word on the commit edge and holds it while the captured address is stable
  assign resp_rdata = resp_load ? arr_rdata : '0;
  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .CLK  (CLK),
    .we   (commit && cur.we && !err),
    .be   (cur.be),
    .addr (offset[ADDR_WIDTH+1:2]),
    .wdata(cur.wdata),
    .rdata(arr_rdata)
  );
endmodule
